// File: rtl/gcd_pkg.sv
// Shared definitions for the subtract-until-equal GCD controller:
// state encoding, datapath mux select encodings and Moore output decode.
package gcd_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CMP    = 3'd3,
    S_SUB_A  = 3'd4,
    S_SUB_B  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic SEL_IN_DATA = 1'b1;
  localparam logic SEL_IN_SUB  = 1'b0;
  localparam logic SEL_A       = 1'b0;
  localparam logic SEL_B       = 1'b1;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic sel_in;
    logic sel1;
    logic sel2;
  } moore_t;

  // Registered outputs are a pure function of the state they will reflect.
  function automatic moore_t moore_decode(input state_e s);
    moore_t m;
    m = 6'b000000;
    case (s)
      S_IDLE: m = 6'b000000;
      S_LOAD_A, S_LOAD_B: begin
        m.busy   = 1'b1;
        m.sel_in = SEL_IN_DATA;
      end
      S_CMP: m.busy = 1'b1;
      S_SUB_A: begin
        m.busy   = 1'b1;
        m.sel_in = SEL_IN_SUB;
        m.sel1   = SEL_A;
        m.sel2   = SEL_B;
      end
      S_SUB_B: begin
        m.busy   = 1'b1;
        m.sel_in = SEL_IN_SUB;
        m.sel1   = SEL_B;
        m.sel2   = SEL_A;
      end
      S_DONE:  m.done = 1'b1;
      S_ERR:   m.err  = 1'b1;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the GCD datapath: operand load handshake, compare/subtract
// sequencing, saturating iteration counter and done/err reporting.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned       ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  input  logic              a_zero,
  input  logic              b_zero,
  output logic              ldA,
  output logic              ldB,
  output logic              sel_in,
  output logic              sel1,
  output logic              sel2,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ITER_W-1:0] iter_r;
  logic [ITER_W-1:0] iter_nxt_s;
  moore_t            moore_r;

  // Next-state and iteration counter update.
  always_comb begin
    state_nxt_s = state_r;
    iter_nxt_s  = iter_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt_s = S_LOAD_A;
          iter_nxt_s  = {ITER_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LOAD_A: begin
        if (in_valid) begin
          state_nxt_s = S_LOAD_B;
        end else begin
          state_nxt_s = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          state_nxt_s = S_CMP;
        end else begin
          state_nxt_s = S_LOAD_B;
        end
      end
      S_CMP: begin
        // Zero operands would never converge, so they abort before eq is trusted.
        if (a_zero || b_zero) begin
          state_nxt_s = S_ERR;
        end else if (eq) begin
          state_nxt_s = S_DONE;
        end else if (iter_r == MAX_ITER) begin
          state_nxt_s = S_ERR;
        end else if (gt) begin
          state_nxt_s = S_SUB_A;
        end else if (lt) begin
          state_nxt_s = S_SUB_B;
        end else begin
          state_nxt_s = S_ERR;
        end
      end
      S_SUB_A, S_SUB_B: begin
        state_nxt_s = S_CMP;
        if (iter_r != MAX_ITER) begin
          iter_nxt_s = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
        end else begin
          iter_nxt_s = iter_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        iter_nxt_s  = {ITER_W{1'b0}};
      end
    endcase
  end

  // Handshake and load enables depend on the live in_valid, so they stay combinational.
  always_comb begin
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    case (state_r)
      S_LOAD_A: begin
        in_ready = 1'b1;
        ldA      = in_valid;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        ldB      = in_valid;
      end
      S_SUB_A: ldA = 1'b1;
      S_SUB_B: ldB = 1'b1;
      default: begin
        in_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
      end
    endcase
  end

  // State, counter and Moore output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      iter_r  <= {ITER_W{1'b0}};
      moore_r <= 6'b000000;
    end else begin
      state_r <= state_nxt_s;
      iter_r  <= iter_nxt_s;
      moore_r <= moore_decode(state_nxt_s);
    end
  end

  assign busy       = moore_r.busy;
  assign done       = moore_r.done;
  assign err        = moore_r.err;
  assign sel_in     = moore_r.sel_in;
  assign sel1       = moore_r.sel1;
  assign sel2       = moore_r.sel2;
  assign iter_count = iter_r;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl with a behavioural model of the GCD datapath.
module tb_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        in_ready, ldA, ldB, sel_in, sel1, sel2, busy, done, err;
  logic        lt, gt, eq, a_zero, b_zero;
  logic [15:0] iter_count;

  logic [15:0] a_reg = 16'd0;
  logic [15:0] b_reg = 16'd0;
  logic [15:0] mux1, mux2, reg_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beat_cyc = 0;
  int ld_pulses = 0;
  logic prev_fin = 1'b0;

  typedef struct {
    bit          is_err;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] iters;
    int          lat;
  } exp_t;
  exp_t sb[$];

  gcd_ctrl #(.ITER_W(16), .MAX_ITER(16'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .lt(lt), .gt(gt), .eq(eq), .a_zero(a_zero), .b_zero(b_zero),
    .ldA(ldA), .ldB(ldB), .sel_in(sel_in), .sel1(sel1), .sel2(sel2),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Datapath model: operand registers, muxes, subtractor, comparator.
  assign mux1   = sel1 ? b_reg : a_reg;
  assign mux2   = sel2 ? b_reg : a_reg;
  assign reg_in = sel_in ? data_in : (mux1 - mux2);
  assign lt     = a_reg < b_reg;
  assign gt     = a_reg > b_reg;
  assign eq     = a_reg == b_reg;
  assign a_zero = a_reg == 16'd0;
  assign b_zero = b_reg == 16'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ldA) a_reg <= reg_in;
    if (ldB) b_reg <= reg_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the expected outcome whenever done or err rises.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_fin = 1'b0;
    end else begin
      if ((ldA || ldB) && !sel_in) ld_pulses++;
      if ((done || err) && !prev_fin) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done", {31'd0, done}, {31'd0, !e.is_err});
          chk("err", {31'd0, err}, {31'd0, e.is_err});
          chk("result_a", {16'd0, a_reg}, {16'd0, e.a});
          chk("result_b", {16'd0, b_reg}, {16'd0, e.b});
          chk("iter_count", {16'd0, iter_count}, {16'd0, e.iters});
          chk("latency", cyc - beat_cyc, e.lat);
          chk("sub_ld_pulses", ld_pulses, {16'd0, e.iters});
        end
      end
      prev_fin = done || err;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("fin_clear_on_start", {30'd0, done, err}, 32'd0);
  endtask

  // Present one operand after stall idle cycles; optionally pulse start mid-stall.
  task automatic feed(input logic [15:0] v, input int stall, input bit pulse, input bit is_b);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b0;
      start = pulse && (i == 1);
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stall_no_ld", {30'd0, ldA, ldB}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    data_in = v;
    in_valid = 1'b1;
    #1;
    chk("beat_ld", {30'd0, ldA, ldB}, is_b ? 32'd1 : 32'd2);
    if (is_b) begin
      beat_cyc = cyc + 1;
      ld_pulses = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!(done || err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit is_err,
                     input logic [15:0] ra, input logic [15:0] rb,
                     input logic [15:0] iters, input int lat,
                     input int sa, input int sbs, input bit pulse);
    exp_t e;
    e.is_err = is_err; e.a = ra; e.b = rb; e.iters = iters; e.lat = lat;
    sb.push_back(e);
    do_start();
    feed(a, sa, pulse, 1'b0);
    feed(b, sbs, pulse, 1'b1);
    if (pulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_fin();
  endtask

  initial begin
    #1;
    chk("reset_outputs", {24'd0, in_ready, ldA, ldB, sel_in, sel1, sel2, busy, done, err} , 32'd0);
    chk("reset_iter", {16'd0, iter_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", {29'd0, in_ready, busy, done}, 32'd0);

    // 48/18: SUB order A,A,B,A -> 6 after 4 iterations.
    run(16'd48, 16'd18, 1'b0, 16'd6, 16'd6, 16'd4, 9, 0, 0, 1'b0);
    // Equal operands finish straight from CMP.
    run(16'd7, 16'd7, 1'b0, 16'd7, 16'd7, 16'd0, 1, 0, 0, 1'b0);
    // Zero operand aborts; next run must clear err.
    run(16'd0, 16'd5, 1'b1, 16'd0, 16'd5, 16'd0, 1, 0, 0, 1'b0);
    run(16'd12, 16'd8, 1'b0, 16'd4, 16'd4, 16'd2, 5, 0, 0, 1'b0);
    // Iteration cap of 8: B walks 20 -> 12 then aborts.
    run(16'd1, 16'd20, 1'b1, 16'd1, 16'd12, 16'd8, 17, 0, 0, 1'b0);
    // Stalled operands and stray start pulses while busy.
    run(16'd9, 16'd6, 1'b0, 16'd3, 16'd3, 16'd2, 5, 5, 3, 1'b1);

    // Reset during SUB_B of a 48/18 run.
    do_start();
    feed(16'd48, 0, 1'b0, 1'b0);
    feed(16'd18, 0, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!(ldB && !sel_in) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("reach_sub_b", {31'd0, (n < 50)}, 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", {23'd0, in_ready, ldA, ldB, sel_in, sel1, sel2, busy, done, err}, 32'd0);
    chk("midrun_reset_iter", {16'd0, iter_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {30'd0, in_ready, busy}, 32'd0);
    run(16'd21, 16'd14, 1'b0, 16'd7, 16'd7, 16'd2, 5, 0, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("done_held", {30'd0, done, err}, 32'd2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
